// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller for the 6502 system bus.
// Collects up to NSRC interrupt requests, applies per-source edge/level mode,
// mask and a global enable, and drives a registered level-sensitive CPU IRQ.
// Firmware reads a priority-encoded source ID. Bit 0 has the highest priority.
//
// Ports:
//   clk    in   CPU clock
//   reset  in   asynchronous active-low reset
//   cs     in   chip select from address decode
//   we     in   write enable, qualified by cs
//   rs     in   register select (CPU_AB[2:0])
//   din    in   CPU write data
//   dout   out  registered read data, valid one cycle after the address
//   src    in   raw interrupt requests, active-high, may be off-chip
//   irq    out  registered interrupt request to the CPU, active-high
//
// Register map (rs): 0 RAW, 1 PEND (W1C), 2 MASK, 3 EDGE, 4 ID, 5 CTRL, 6/7 zero.
module irq_ctrl #(
  parameter int unsigned NSRC = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cs,
  input  logic            we,
  input  logic [2:0]      rs,
  input  logic [7:0]      din,
  output logic [7:0]      dout,
  input  logic [NSRC-1:0] src,
  output logic            irq
);

  logic [NSRC-1:0] s1_q, s2_q, prev_q;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] mask_q, edge_q;
  logic            gie_q;
  logic [7:0]      dout_q, dout_d;
  logic            irq_q, irq_d;

  logic [NSRC-1:0] rise, active, din_src;
  logic            wr, rd, wr_pend, wr_mask, wr_edge, wr_ctrl;
  logic            id_any;
  logic [2:0]      id_idx;

  assign wr      = cs & we;
  assign rd      = cs & ~we;
  assign wr_pend = wr & (rs == 3'd1);
  assign wr_mask = wr & (rs == 3'd2);
  assign wr_edge = wr & (rs == 3'd3);
  assign wr_ctrl = wr & (rs == 3'd5);
  assign din_src = din[NSRC-1:0];

  assign rise   = s2_q & ~prev_q;
  assign active = pend_q & mask_q;

  // Pending update. Switching a bit into edge mode discards its old level
  // state; a detected edge always beats a W1C or a mode-switch clear.
  always_comb begin
    pend_d = pend_q;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (wr_edge && din_src[i] && !edge_q[i]) begin
        pend_d[i] = rise[i];
      end else if (edge_q[i]) begin
        if (rise[i]) begin
          pend_d[i] = 1'b1;
        end else if (wr_pend && din_src[i]) begin
          pend_d[i] = 1'b0;
        end
      end else begin
        pend_d[i] = s2_q[i];
      end
    end
  end

  // Lowest-numbered active source wins.
  always_comb begin
    id_any = |active;
    id_idx = '0;
    for (int unsigned i = NSRC; i > 0; i--) begin
      if (active[i-1]) begin
        id_idx = 3'(i - 1);
      end
    end
  end

  always_comb begin
    dout_d = dout_q;
    if (rd) begin
      dout_d = '0;
      unique case (rs)
        3'd0: dout_d[NSRC-1:0] = s2_q;
        3'd1: dout_d[NSRC-1:0] = pend_q;
        3'd2: dout_d[NSRC-1:0] = mask_q;
        3'd3: dout_d[NSRC-1:0] = edge_q;
        3'd4: dout_d = {id_any, 4'b0000, id_idx};
        3'd5: dout_d[0] = gie_q;
        default: dout_d = '0;
      endcase
    end
  end

  assign irq_d = gie_q & (|active);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      pend_q <= '0;
      mask_q <= '0;
      edge_q <= '0;
      gie_q  <= 1'b0;
      dout_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      s1_q   <= src;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      pend_q <= pend_d;
      dout_q <= dout_d;
      irq_q  <= irq_d;
      if (wr_mask) mask_q <= din_src;
      if (wr_edge) edge_q <= din_src;
      if (wr_ctrl) gie_q  <= din[0];
    end
  end

  assign dout = dout_q;
  assign irq  = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed-vector bench for irq_ctrl with hand-computed
// expectations. Inputs are driven on the falling edge, outputs sampled 1 ns
// after the rising edge.
module tb_irq_ctrl;

  logic       clk;
  logic       reset;
  logic       cs;
  logic       we;
  logic [2:0] rs;
  logic [7:0] din;
  logic [7:0] dout;
  logic [7:0] src;
  logic       irq;

  int total;
  int bad;

  irq_ctrl #(.NSRC(8)) dut (
    .clk   (clk),
    .reset (reset),
    .cs    (cs),
    .we    (we),
    .rs    (rs),
    .din   (din),
    .dout  (dout),
    .src   (src),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; rs = a; din = d;
    @(posedge clk);
    #1;
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; rs = a;
    @(posedge clk);
    #1;
    d = dout;
    cs = 1'b0;
  endtask

  task automatic pulse(input int unsigned bitn);
    @(negedge clk);
    src[bitn] = 1'b1;
    @(negedge clk);
    src[bitn] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] r;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    cs = 1'b0; we = 1'b0; rs = '0; din = '0;
    src = 8'hFF;

    // Reset held with all sources high
    repeat (3) tick();
    chk("rst_dout", dout, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);

    // Release and read RAW continuously; data valid from the third clock
    @(negedge clk);
    reset = 1'b1;
    cs = 1'b1; we = 1'b0; rs = 3'd0;
    tick(); chk("raw_e1", dout, 8'h00);
    tick(); chk("raw_e2", dout, 8'h00);
    tick(); chk("raw_e3", dout, 8'hFF);
    cs = 1'b0;
    chk("post_rst_irq", {7'b0, irq}, 8'h00);

    @(negedge clk);
    src = 8'h00;
    repeat (4) tick();
    for (int i = 1; i < 8; i++) begin
      rd(3'(i), r);
      chk($sformatf("zero_rs%0d", i), r, 8'h00);
    end

    // Level path
    wr(3'd2, 8'h04);
    wr(3'd5, 8'h01);
    rd(3'd5, r); chk("ctrl_rd", r, 8'h01);
    @(negedge clk);
    src[2] = 1'b1;
    tick(); chk("lvl_up_k",  {7'b0, irq}, 8'h00);
    tick(); chk("lvl_up_k1", {7'b0, irq}, 8'h00);
    tick(); chk("lvl_up_k2", {7'b0, irq}, 8'h00);
    tick(); chk("lvl_up_k3", {7'b0, irq}, 8'h01);
    wr(3'd1, 8'h04);
    rd(3'd1, r); chk("lvl_w1c_pend", r, 8'h04);
    chk("lvl_w1c_irq", {7'b0, irq}, 8'h01);
    rd(3'd4, r); chk("lvl_id", r, 8'h82);
    @(negedge clk);
    src[2] = 1'b0;
    tick(); chk("lvl_dn_k",  {7'b0, irq}, 8'h01);
    tick(); chk("lvl_dn_k1", {7'b0, irq}, 8'h01);
    tick(); chk("lvl_dn_k2", {7'b0, irq}, 8'h01);
    tick(); chk("lvl_dn_k3", {7'b0, irq}, 8'h00);
    rd(3'd1, r); chk("lvl_dn_pend", r, 8'h00);

    // Edge path
    wr(3'd3, 8'h10);
    wr(3'd2, 8'h10);
    pulse(4);
    repeat (4) tick();
    rd(3'd1, r); chk("edg_pend", r, 8'h10);
    chk("edg_irq", {7'b0, irq}, 8'h01);
    rd(3'd0, r); chk("edg_raw", r, 8'h00);
    wr(3'd1, 8'h10);
    chk("edg_w1c_k", {7'b0, irq}, 8'h01);
    tick(); chk("edg_w1c_k1", {7'b0, irq}, 8'h00);
    rd(3'd1, r); chk("edg_w1c_pend", r, 8'h00);

    // Edge detection coinciding with a W1C of the same bit
    wr(3'd3, 8'h12);
    wr(3'd2, 8'h12);
    pulse(1);
    repeat (4) tick();
    rd(3'd1, r); chk("sim_pre_pend", r, 8'h02);
    @(negedge clk);
    src[1] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    wr(3'd1, 8'h02);
    chk("sim_irq_k2", {7'b0, irq}, 8'h01);
    tick(); chk("sim_irq_k3", {7'b0, irq}, 8'h01);
    rd(3'd1, r); chk("sim_pend", r, 8'h02);
    wr(3'd1, 8'h02);
    rd(3'd1, r); chk("sim_clr_pend", r, 8'h00);
    chk("sim_clr_irq", {7'b0, irq}, 8'h00);
    @(negedge clk);
    src[1] = 1'b0;

    // Priority / ID
    wr(3'd3, 8'h00);
    @(negedge clk);
    src = 8'h68;
    repeat (4) tick();
    wr(3'd2, 8'h60);
    rd(3'd4, r); chk("id_60", r, 8'h85);
    chk("id_irq", {7'b0, irq}, 8'h01);
    wr(3'd2, 8'h40);
    rd(3'd4, r); chk("id_40", r, 8'h86);
    wr(3'd2, 8'h00);
    tick(); chk("id_m0_irq", {7'b0, irq}, 8'h00);
    rd(3'd4, r); chk("id_00", r, 8'h00);
    rd(3'd1, r); chk("id_pend", r, 8'h68);

    // Reset mid-operation
    @(negedge clk);
    src = 8'h00;
    repeat (4) tick();
    wr(3'd3, 8'h01);
    wr(3'd2, 8'h01);
    pulse(0);
    repeat (4) tick();
    rd(3'd1, r); chk("mid_pend", r, 8'h01);
    chk("mid_irq", {7'b0, irq}, 8'h01);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_irq", {7'b0, irq}, 8'h00);
    chk("mid_rst_dout", dout, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    rd(3'd1, r); chk("mid_pend0", r, 8'h00);
    rd(3'd2, r); chk("mid_mask0", r, 8'h00);
    rd(3'd3, r); chk("mid_edge0", r, 8'h00);
    rd(3'd5, r); chk("mid_ctrl0", r, 8'h00);
    pulse(0);
    repeat (6) tick();
    chk("mid_no_irq", {7'b0, irq}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt controller for the 6502 system. It collects up to eight peripheral interrupt requests (ACIA, timers, GPIO) and applies per-source edge/level mode, mask and global enable. It drives the single level-sensitive CPU IRQ line and gives firmware a priority-encoded source ID. It sits on the CPU bus as a memory-mapped peripheral page, using the same chip-select, write-enable and register-select convention as the ACIA, and returns registered read data one cycle after the address.

## Interface
- NSRC, 8, number of interrupt sources, 1..8; unused upper bits read 0 and ignore writes

- clk  in  1  CPU clock
- reset  in  1  asynchronous, active-low reset
- cs  in  1  chip select from address decode
- we  in  1  CPU write enable; qualified by cs
- rs  in  3  register select, CPU_AB[2:0]
- din  in  8  CPU write data
- dout  out  8  registered read data
- src  in  NSRC  raw interrupt requests, active-high, asynchronous to nothing but possibly from off-chip
- irq  out  1  registered interrupt request to CPU, active-high

## Operation
- Input path: each src bit passes through a 2-FF synchronizer (s1, s2); then a prev register holds the last s2 value.
- Register map, by rs value:
  - 0 RAW (RO): s2.
  - 1 PEND (R, W1C): pending vector.
  - 2 MASK (RW): 1 = enabled.
  - 3 EDGE (RW): 1 = rising-edge mode, 0 = level mode.
  - 4 ID (RO): bit7 = any active, bits[2:0] = index of lowest-numbered active bit, bits[6:3] = 0. "Active" means pend & mask.
  - 5 CTRL (RW): bit0 = GIE; other bits read 0.
  - 6, 7: read 0, writes ignored.
- Pending register update, per bit i, every clock:
  - Level mode: pend[i] <= s2[i]. W1C has no effect.
  - Edge mode: if s2[i] & ~prev[i], pend[i] <= 1. Otherwise, a W1C write with din[i]=1 sets pend[i] <= 0. An edge in the same cycle as the clear wins, so the bit stays 1.
  - Write to EDGE that changes bit i from 0 to 1: pend[i] <= 0 that cycle, unless an edge is also detected.
- irq <= GIE & |(pend & mask), registered.
- Priority: bit 0 is highest. ID is a snapshot only; reading it has no side effect.
- Writes take effect on the clock edge where cs=1 and we=1. A read (cs=1, we=0) loads dout on that edge. When cs=0, dout holds its value.
- Reads have no side effects on any register.

## Timing
- Reset (asynchronous, reset=0) clears s1, s2, prev, pend, MASK, EDGE, GIE, dout and irq to 0. Outputs stay 0 until the first clock after reset deasserts.
- src rising before edge k:
  - s1 = 1 at k, s2 = 1 at k+1, pend = 1 at k+2, irq = 1 at k+3, given GIE and mask already set.
- Level-mode src falling before edge k: pend = 0 at k+2, irq = 0 at k+3.
- W1C write at edge k (edge mode): pend = 0 at k; irq = 0 at k+1 if no other active bit.
- MASK or CTRL write at edge k: irq reflects it at k+1.
- Read data: the address is presented during cycle k and dout is valid after edge k. This matches the CPU's one-cycle-delayed data mux.
- Because prev resets to 0, a src held high through reset produces one edge-mode pend if EDGE is already set when s2 rises. In practice s2 rises 2 cycles after reset release, before firmware can set EDGE, so no spurious edge pend occurs.
- Reset asserted mid-operation clears all state immediately. Any pending edge events are lost.

## Test plan
- Reset: hold reset=0 with src=8'hFF. Required: dout=0 and irq=0; after release, all registers read 0 except RAW=8'hFF (valid from the third clock).
- Level path: write MASK=8'h04 and CTRL=1, then raise src[2] before edge k. Required: irq=1 exactly at k+3. Drop src[2] → irq=0 at k+3 after the drop. W1C to PEND has no effect while src[2] is high.
- Edge path:
  - Set EDGE=8'h10, MASK=8'h10, GIE=1, then pulse src[4] for 1 cycle. Required: PEND=8'h10 and irq=1 latched.
  - Write PEND=8'h10. Required: irq=0 on the next edge.
- Simultaneous edge and clear: time the src[1] rising edge detection to coincide with a W1C of bit 1. Required: PEND bit 1 remains 1 and irq stays 1.
- Priority/ID: make bits 3, 5 and 6 active with MASK=8'h60. Required: ID=8'h85. Then clear mask bit 5. Required: ID=8'h86. Then MASK=0. Required: ID=8'h00 and irq=0 while PEND is unchanged.
- Reset mid-operation: with PEND=8'h01 latched and irq=1, pulse reset=0 for 1 cycle. Required: irq=0, PEND/MASK/EDGE/CTRL=0 immediately, and no irq afterwards until reprogrammed.
